pipe_pattern_source: RTL and testbench
======================================

// Module: pipe_pattern_source
// PURPOSE
//  Buffered LFSR/counter word source feeding the okPipeOut endpoint at addr 0xA0 on okClk.
//  - A generator fills a first-word-fall-through (FWFT) FIFO.
//  - pipe_datain always shows the FIFO head; each pipe_read pops one word.
//  - Control arrives as a TriggerIn mode vector (ep 0x40) plus a seed from a WireIn (ep 0x01).
//  - Status (word count, sticky underflow) goes back to the host through WireOuts.
// PARAMETERS
//  FIFO_DEPTH  16            entries; power of 2, 4..256
//  SEED_INIT   32'h0000_0001 generator value after reset
// PORTS
//  okClk        in   1   clock
//  reset        in   1   synchronous, active-high
//  mode_trig    in   5   one-cycle trigger pulses:
//                          [0] LFSR  [1] COUNTER  [2] STOP  [3] START  [4] CLR_STATUS
//  seed_in      in   32  seed value (WireIn)
//  seed_load    in   1   1-cycle pulse: load seed_in into generator
//  pipe_read    in   1   okPipeOut ep_read; pops the FIFO head
//  pipe_datain  out  32  okPipeOut ep_datain; the FIFO head
//  fifo_level   out  log2(FIFO_DEPTH)+1  current occupancy
//  word_count   out  32  pipe_read pulses since reset/CLR_STATUS; wraps at 2^32
//  underflow    out  1   sticky: pipe_read seen while FIFO empty
//  running      out  1   state==RUN
// BEHAVIOUR
//  Reset values (all outputs, on the reset cycle)
//   - state=IDLE, pattern=LFSR, gen=SEED_INIT, FIFO empty
//   - pipe_datain=0, fifo_level=0, word_count=0, underflow=0, running=0
//   - reset overrides every other input, including mid-stream; FIFO contents are discarded.
//  States
//   - IDLE: generator frozen, no pushes.
//     START -> RUN. STOP -> IDLE and flush the FIFO.
//   - RUN: push gen into the FIFO on every cycle the FIFO is not full, then advance gen.
//     STOP -> IDLE and flush the FIFO.
//  Generator
//   - LFSR step: gen <= {gen[30:0], gen[31]^gen[21]^gen[1]}.
//   - COUNTER step: gen <= gen + 1 (mod 2^32).
//   - A zero value in LFSR mode (via seed or mode switch) is replaced by 32'h1.
//  Trigger rules
//   - LFSR/COUNTER select the pattern in any state; takes effect on the next generated word.
//     Words already in the FIFO are kept.
//   - Both [0] and [1] set in one cycle: COUNTER wins.
//   - Both START and STOP set: STOP wins; state ends in IDLE.
//   - CLR_STATUS zeroes word_count and underflow next cycle.
//     If a pipe_read occurs in the same cycle, the clear wins.
//  seed_load
//   - Loads seed_in into gen and flushes the FIFO in the same cycle; state is unchanged.
//   - The first pushed word equals the seed (after the LFSR zero substitution).
//  FIFO
//   - FWFT: pipe_datain valid combinationally from the head register.
//   - A push into an empty FIFO appears on pipe_datain the next cycle, so the first-word
//     latency from START or seed_load is 2 cycles.
//   - Simultaneous push and pop when not empty: level unchanged.
//   - Pop when full: the push is allowed in the same cycle.
//   - Pointers wrap modulo FIFO_DEPTH; fifo_level saturates at FIFO_DEPTH with no push
//     while full.
//   - pipe_read when empty: no pop, pipe_datain holds 0, underflow<=1, word_count
//     still increments.
//   - Flush sets level=0 and pipe_datain=0 on the next cycle.
//  word_count increments once per pipe_read cycle; a continuously held pipe_read counts
//  every cycle.
// TESTING
//  1. Reset; COUNTER; seed_in=0, seed_load; START; wait 20 cycles.
//     -> fifo_level=16; 4 reads return 0,1,2,3; word_count=4.
//  2. Reset; LFSR; seed 1; START; 4 reads.
//     -> 1, 2, 5, 10. Repeat with seed 0 -> identical sequence (zero substitution).
//  3. Reset; START immediately and hold pipe_read high from cycle 0.
//     -> underflow=1 on the early empty reads, pipe_datain=0 while empty; then a
//        contiguous sequence with no duplicates or gaps.
//  4. COUNTER RUN, FIFO full; assert STOP and START together.
//     -> IDLE, level=0 next cycle.
//     Then START -> the next word continues the counter (gen not reset).
//  5. Mid-stream: seed_load 32'h100 while reading continuously.
//     -> the following read returns 32'h100 once the 2-cycle latency elapses;
//        no pre-seed word after it.
//  6. Assert reset during RUN with reads active.
//     -> all outputs at reset values next cycle; CLR_STATUS plus a read in the same
//        cycle gives word_count=0.

Source files
------------

// File: rtl/pipe_pattern_source.sv
// Purpose : LFSR/counter word generator buffered in a FWFT FIFO feeding an okPipeOut endpoint.
// Latency : 2 cycles from START or seed_load to the first word on pipe_datain; pops take effect next cycle.
// Backpr. : generator stalls while the FIFO is full; a pop while full frees the slot for a same-cycle push.
//
// Ports
//   okClk        clock
//   reset        synchronous, active-high; overrides every other input
//   mode_trig    one-cycle triggers: [0] LFSR [1] COUNTER [2] STOP [3] START [4] CLR_STATUS
//   seed_in      seed value, loaded on seed_load
//   seed_load    loads seed_in into the generator and flushes the FIFO
//   pipe_read    pops the FIFO head (ep_read)
//   pipe_datain  FIFO head, 0 while empty (ep_datain)
//   fifo_level   current FIFO occupancy
//   word_count   pipe_read cycles since reset / CLR_STATUS, wraps at 2^32
//   underflow    sticky flag: pipe_read seen while the FIFO was empty
//   running      generator is in the RUN state

module pipe_pattern_source #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] SEED_INIT  = 32'h0000_0001
) (
    input  logic                          okClk,
    input  logic                          reset,
    input  logic [4:0]                    mode_trig,
    input  logic [31:0]                   seed_in,
    input  logic                          seed_load,
    input  logic                          pipe_read,
    output logic [31:0]                   pipe_datain,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [31:0]                   word_count,
    output logic                          underflow,
    output logic                          running
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Trigger decode
    // ------------------------------------------------------------------
    logic w_trg_lfsr;
    logic w_trg_cnt;
    logic w_trg_stop;
    logic w_trg_start;
    logic w_trg_clr;

    assign w_trg_lfsr  = mode_trig[0];
    assign w_trg_cnt   = mode_trig[1];
    assign w_trg_stop  = mode_trig[2];
    assign w_trg_start = mode_trig[3];
    assign w_trg_clr   = mode_trig[4];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_pat_cnt;        // 1 = counter pattern, 0 = LFSR
    logic                w_pat_cnt_nxt;
    logic [31:0]         r_gen;
    logic [31:0]         w_gen_nxt;
    logic [31:0]         w_gen_step;

    logic [31:0]         r_mem [FIFO_DEPTH];
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [LW-1:0]       r_level;
    logic [31:0]         r_word_count;
    logic                r_underflow;

    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_flush;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LVL_FULL);
    // An empty pop is not a pop: nothing moves, only the status reacts.
    assign w_pop   = pipe_read && !w_empty;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge okClk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state, flush and push decisions
    // STOP outranks START. seed_load flushes without touching the state.
    // A flushing cycle never pushes, so the first word after a flush is
    // the value the generator holds once the flush is done.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_flush     = 1'b0;
        w_push      = 1'b0;

        if (w_trg_stop) begin
            w_state_nxt = ST_IDLE;
            w_flush     = 1'b1;
        end else if (w_trg_start) begin
            w_state_nxt = ST_RUN;
        end

        if (seed_load) begin
            w_flush = 1'b1;
        end

        if ((r_state == ST_RUN) && !w_flush && (!w_full || w_pop)) begin
            w_push = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Pattern select: COUNTER wins when both pattern triggers fire.
    // ------------------------------------------------------------------
    always_comb begin
        w_pat_cnt_nxt = r_pat_cnt;
        if (w_trg_cnt) begin
            w_pat_cnt_nxt = 1'b1;
        end else if (w_trg_lfsr) begin
            w_pat_cnt_nxt = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Generator. The step after a push uses the newly selected pattern,
    // so a pattern switch shows up on the next generated word. Zero is a
    // lock-up state for the LFSR and is replaced by 1 whenever the
    // generator would hold zero in LFSR mode.
    // ------------------------------------------------------------------
    always_comb begin
        if (w_pat_cnt_nxt) begin
            w_gen_step = r_gen + 32'd1;
        end else begin
            w_gen_step = {r_gen[30:0], r_gen[31] ^ r_gen[21] ^ r_gen[1]};
        end

        w_gen_nxt = r_gen;
        if (seed_load) begin
            w_gen_nxt = seed_in;
        end else if (w_push) begin
            w_gen_nxt = w_gen_step;
        end

        if (!w_pat_cnt_nxt && (w_gen_nxt == 32'd0)) begin
            w_gen_nxt = 32'd1;
        end
    end

    always_ff @(posedge okClk) begin
        if (reset) begin
            r_pat_cnt <= 1'b0;
            r_gen     <= SEED_INIT;
        end else begin
            r_pat_cnt <= w_pat_cnt_nxt;
            r_gen     <= w_gen_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage. Contents need no reset: the level gates visibility.
    // ------------------------------------------------------------------
    always_ff @(posedge okClk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_gen;
        end
    end

    always_ff @(posedge okClk) begin
        if (reset || w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Host status. CLR_STATUS outranks a same-cycle read.
    // ------------------------------------------------------------------
    always_ff @(posedge okClk) begin
        if (reset || w_trg_clr) begin
            r_word_count <= 32'd0;
            r_underflow  <= 1'b0;
        end else if (pipe_read) begin
            r_word_count <= r_word_count + 32'd1;
            if (w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The head is shown combinationally (first-word fall-through)
    // and forced to zero while empty.
    // ------------------------------------------------------------------
    assign pipe_datain = w_empty ? 32'd0 : r_mem[r_rd_ptr];
    assign fifo_level  = r_level;
    assign word_count  = r_word_count;
    assign underflow   = r_underflow;
    assign running     = (r_state == ST_RUN);

endmodule

// File: tb/tb_pipe_pattern_source.sv
module tb_pipe_pattern_source;

    localparam logic [4:0] T_LFSR  = 5'b00001;
    localparam logic [4:0] T_CNT   = 5'b00010;
    localparam logic [4:0] T_STOP  = 5'b00100;
    localparam logic [4:0] T_START = 5'b01000;
    localparam logic [4:0] T_CLR   = 5'b10000;

    logic        okClk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  mode_trig = '0;
    logic [31:0] seed_in = '0;
    logic        seed_load = 1'b0;
    logic        pipe_read = 1'b0;
    logic [31:0] pipe_datain;
    logic [4:0]  fifo_level;
    logic [31:0] word_count;
    logic        underflow;
    logic        running;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic        chk;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];

    pipe_pattern_source #(
        .FIFO_DEPTH (16),
        .SEED_INIT  (32'h0000_0001)
    ) dut (
        .okClk       (okClk),
        .reset       (reset),
        .mode_trig   (mode_trig),
        .seed_in     (seed_in),
        .seed_load   (seed_load),
        .pipe_read   (pipe_read),
        .pipe_datain (pipe_datain),
        .fifo_level  (fifo_level),
        .word_count  (word_count),
        .underflow   (underflow),
        .running     (running)
    );

    always #5 okClk = ~okClk;

    // Monitor: every read cycle consumes one scoreboard entry.
    always @(negedge okClk) begin
        exp_t e;
        if (pipe_read) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_underrun: read with no expectation, data=%h", pipe_datain);
            end else begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    n_checks++;
                    if (pipe_datain !== e.val) begin
                        n_errors++;
                        $display("FAIL read_data: got %h expected %h (t=%0t)", pipe_datain, e.val, $time);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge okClk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic rd(input logic chk, input logic [31:0] v);
        pipe_read = 1'b1;
        exp_q.push_back({chk, v});
        tick();
        pipe_read = 1'b0;
    endtask

    task automatic trig(input logic [4:0] m);
        mode_trig = m;
        tick();
        mode_trig = '0;
    endtask

    task automatic load_seed(input logic [31:0] s);
        seed_in   = s;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        pipe_read = 1'b0;
        mode_trig = '0;
        seed_load = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_datain"},  pipe_datain, 32'd0);
        check({tag, "_level"},   32'(fifo_level), 32'd0);
        check({tag, "_wcount"},  word_count, 32'd0);
        check({tag, "_uflow"},   32'(underflow), 32'd0);
        check({tag, "_running"}, 32'(running), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        check_reset_state("rst0");

        // ---------------- 1: counter fill, reads while full ----------------
        trig(T_CNT);
        load_seed(32'd0);
        trig(T_START);
        check("t1_running", 32'(running), 32'd1);
        repeat (20) tick();
        check("t1_level_full", 32'(fifo_level), 32'd16);
        rd(1'b1, 32'd0);
        rd(1'b1, 32'd1);
        rd(1'b1, 32'd2);
        rd(1'b1, 32'd3);
        check("t1_wcount", word_count, 32'd4);
        check("t1_level_refill", 32'(fifo_level), 32'd16);
        check("t1_uflow", 32'(underflow), 32'd0);

        // ---------------- 4: STOP+START while full, then resume ----------------
        trig(T_STOP | T_START);
        check("t4_running", 32'(running), 32'd0);
        check("t4_level", 32'(fifo_level), 32'd0);
        check("t4_datain", pipe_datain, 32'd0);
        trig(T_START);
        tick();
        rd(1'b1, 32'd20);
        rd(1'b1, 32'd21);

        // ---------------- 2: LFSR from seed 1, then seed 0 ----------------
        do_reset();
        trig(T_LFSR);
        load_seed(32'd1);
        trig(T_START);
        tick();
        rd(1'b1, 32'd1);
        rd(1'b1, 32'd2);
        rd(1'b1, 32'd5);
        rd(1'b1, 32'd10);

        do_reset();
        trig(T_LFSR);
        load_seed(32'd0);
        trig(T_START);
        tick();
        rd(1'b1, 32'd1);
        rd(1'b1, 32'd2);
        rd(1'b1, 32'd5);
        rd(1'b1, 32'd10);

        // Both pattern triggers: counter wins.
        do_reset();
        trig(T_LFSR | T_CNT);
        load_seed(32'd5);
        trig(T_START);
        tick();
        rd(1'b1, 32'd5);
        rd(1'b1, 32'd6);

        // Switching to LFSR while the generator holds zero gives 1.
        do_reset();
        trig(T_CNT);
        load_seed(32'd0);
        trig(T_LFSR);
        trig(T_START);
        tick();
        rd(1'b1, 32'd1);
        rd(1'b1, 32'd2);

        // ---------------- 3: START with reads held from cycle 0 ----------------
        do_reset();
        mode_trig = T_START;
        rd(1'b1, 32'd0);
        mode_trig = '0;
        rd(1'b1, 32'd0);
        rd(1'b1, 32'd1);
        rd(1'b1, 32'd2);
        rd(1'b1, 32'd5);
        rd(1'b1, 32'd10);
        rd(1'b1, 32'd21);
        rd(1'b1, 32'd42);
        check("t3_uflow", 32'(underflow), 32'd1);
        check("t3_wcount", word_count, 32'd8);
        check("t3_level", 32'(fifo_level), 32'd1);

        // ---------------- 5: mid-stream seed load ----------------
        do_reset();
        trig(T_CNT);
        load_seed(32'h10);
        trig(T_START);
        tick();
        rd(1'b1, 32'h10);
        rd(1'b1, 32'h11);
        seed_in   = 32'h100;
        seed_load = 1'b1;
        rd(1'b1, 32'h12);
        seed_load = 1'b0;
        rd(1'b1, 32'h0);
        rd(1'b1, 32'h100);
        rd(1'b1, 32'h101);
        check("t5_running", 32'(running), 32'd1);
        check("t5_uflow", 32'(underflow), 32'd1);
        check("t5_wcount", word_count, 32'd6);

        // ---------------- 6: reset mid-stream, CLR_STATUS vs read ----------------
        reset = 1'b1;
        rd(1'b1, 32'h102);
        reset = 1'b0;
        check_reset_state("rst6");
        rd(1'b1, 32'd0);
        check("t6_wcount_pre", word_count, 32'd1);
        check("t6_uflow_pre", 32'(underflow), 32'd1);
        mode_trig = T_CLR;
        rd(1'b1, 32'd0);
        mode_trig = '0;
        check("t6_wcount_clr", word_count, 32'd0);
        check("t6_uflow_clr", 32'(underflow), 32'd0);

        tick();
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
